// File: rtl/tt_lut_pkg.sv
// Shared types and constants for the truth-table LUT evaluator.
package tt_lut_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SWEEP = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [15:0] DEFAULT_TT = 16'hD4E4;

    // Number of config beats needed to fill one truth table.
    function automatic int beats(input int tt_w, input int cfg_w);
        return tt_w / cfg_w;
    endfunction

endpackage

// File: rtl/tt_cfg_shift.sv
// Shadow truth-table assembly: one config beat per accepted handshake,
// least significant chunk first, with a commit strobe on the final beat.
module tt_cfg_shift
    import tt_lut_pkg::*;
#(
    parameter int              TT_W     = 16,
    parameter int              CFG_W    = 4,
    parameter logic [TT_W-1:0] RESET_TT = DEFAULT_TT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             beat_acc,
    input  logic [CFG_W-1:0] cfg_data,
    output logic [TT_W-1:0]  shadow_next,
    output logic             commit
);

    localparam int N_BEATS = beats(TT_W, CFG_W);
    localparam int CNT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(N_BEATS - 1);

    logic [CNT_W-1:0]   chunk_q, chunk_d;
    logic [TT_W-1:0]    shadow_q, shadow_d;
    logic [N_BEATS-1:0] chunk_we;

    genvar gi;
    generate
        for (gi = 0; gi < N_BEATS; gi++) begin : g_chunk_we
            assign chunk_we[gi] = beat_acc && (chunk_q == CNT_W'(gi));
        end
    endgenerate

    always_comb begin
        shadow_d = shadow_q;
        chunk_d  = chunk_q;
        commit   = beat_acc && (chunk_q == LAST_CHUNK);
        for (int i = 0; i < N_BEATS; i++) begin
            if (chunk_we[i]) begin
                shadow_d[i*CFG_W +: CFG_W] = cfg_data;
            end
        end
        if (beat_acc) begin
            chunk_d = commit ? '0 : chunk_q + CNT_W'(1);
        end
    end

    // The top commits this value, so the final chunk lands in the same edge.
    assign shadow_next = shadow_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= RESET_TT;
            chunk_q  <= '0;
        end else begin
            shadow_q <= shadow_d;
            chunk_q  <= chunk_d;
        end
    end

endmodule

// File: rtl/tt_lut_eval.sv
// Reconfigurable N-input LUT with registered output, beat-wise table loading
// and a self-check sweep against a golden truth table.
module tt_lut_eval
    import tt_lut_pkg::*;
#(
    parameter int                     N_IN     = 4,
    parameter int                     CFG_W    = 4,
    parameter logic [(2**N_IN)-1:0]   RESET_TT = DEFAULT_TT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_IN-1:0]        in_vec,
    output logic                   out,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [CFG_W-1:0]       cfg_data,
    input  logic                   sweep_start,
    input  logic [(2**N_IN)-1:0]   golden_tt,
    output logic                   sweep_busy,
    output logic                   sweep_done,
    output logic [N_IN:0]          mism_cnt,
    output logic [N_IN-1:0]        first_mism
);

    localparam int TT_W  = 2**N_IN;
    localparam int CNT_W = N_IN + 1;
    localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};

    state_e            state_q, state_d;
    logic [TT_W-1:0]   active_tt_q, active_tt_d;
    logic              out_q, out_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]  mism_cnt_q, mism_cnt_d;
    logic [N_IN-1:0]   first_mism_q, first_mism_d;
    logic              beat_acc;
    logic              commit;
    logic              entry_mism;
    logic [TT_W-1:0]   shadow_next;

    // cfg_ready is only ever high in IDLE or LOAD, so this is the full handshake.
    assign beat_acc = cfg_valid && cfg_ready_q;

    tt_cfg_shift #(
        .TT_W     (TT_W),
        .CFG_W    (CFG_W),
        .RESET_TT (RESET_TT)
    ) u_cfg_shift (
        .clk         (clk),
        .rst_n       (rst_n),
        .beat_acc    (beat_acc),
        .cfg_data    (cfg_data),
        .shadow_next (shadow_next),
        .commit      (commit)
    );

    always_comb begin
        state_d      = state_q;
        active_tt_d  = active_tt_q;
        idx_d        = idx_q;
        mism_cnt_d   = mism_cnt_q;
        first_mism_d = first_mism_q;
        out_d        = active_tt_q[in_vec];
        entry_mism   = active_tt_q[idx_q] ^ golden_tt[idx_q];

        if (commit) begin
            active_tt_d = shadow_next;
        end

        case (state_q)
            ST_IDLE: begin
                // An accepted beat takes priority over a coincident sweep request.
                if (beat_acc) begin
                    if (!commit) begin
                        state_d = ST_LOAD;
                    end
                end else if (sweep_start) begin
                    state_d      = ST_SWEEP;
                    idx_d        = '0;
                    mism_cnt_d   = '0;
                    first_mism_d = '0;
                end
            end
            ST_LOAD: begin
                if (commit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (entry_mism) begin
                    mism_cnt_d = mism_cnt_q + CNT_W'(1);
                    if (mism_cnt_q == '0) begin
                        first_mism_d = idx_q;
                    end
                end
                // idx parks on the last entry instead of wrapping.
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + N_IN'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cfg_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            active_tt_q  <= RESET_TT;
            out_q        <= 1'b0;
            cfg_ready_q  <= 1'b0;
            idx_q        <= '0;
            mism_cnt_q   <= '0;
            first_mism_q <= '0;
        end else begin
            state_q      <= state_d;
            active_tt_q  <= active_tt_d;
            out_q        <= out_d;
            cfg_ready_q  <= cfg_ready_d;
            idx_q        <= idx_d;
            mism_cnt_q   <= mism_cnt_d;
            first_mism_q <= first_mism_d;
        end
    end

    assign out        = out_q;
    assign cfg_ready  = cfg_ready_q;
    assign sweep_busy = (state_q == ST_SWEEP);
    assign sweep_done = (state_q == ST_DONE);
    assign mism_cnt   = mism_cnt_q;
    assign first_mism = first_mism_q;

endmodule

// File: tb/tb_tt_lut_eval.sv
// Scoreboard bench for tt_lut_eval: expected out bits and sweep results are
// queued when stimulus is applied and popped when the DUT produces them.
module tb_tt_lut_eval;

    localparam int N_IN  = 4;
    localparam int CFG_W = 4;
    localparam int TT_W  = 16;
    localparam logic [TT_W-1:0] RST_TT = 16'hD4E4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N_IN-1:0]   in_vec;
    logic              out;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CFG_W-1:0]  cfg_data;
    logic              sweep_start;
    logic [TT_W-1:0]   golden_tt;
    logic              sweep_busy;
    logic              sweep_done;
    logic [N_IN:0]     mism_cnt;
    logic [N_IN-1:0]   first_mism;

    typedef struct packed {
        logic [N_IN:0]   cnt;
        logic [N_IN-1:0] first;
    } sweep_exp_t;

    int              n_chk  = 0;
    int              n_fail = 0;
    logic [TT_W-1:0] mdl_tt;
    logic            exp_out_q[$];
    sweep_exp_t      sweep_q[$];

    always #5 clk = ~clk;

    tt_lut_eval #(
        .N_IN     (N_IN),
        .CFG_W    (CFG_W),
        .RESET_TT (RST_TT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_vec      (in_vec),
        .out         (out),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_data    (cfg_data),
        .sweep_start (sweep_start),
        .golden_tt   (golden_tt),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done),
        .mism_cnt    (mism_cnt),
        .first_mism  (first_mism)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: queue the out bit the table in force must produce, then check it.
    task automatic step();
        exp_out_q.push_back(mdl_tt[in_vec]);
        @(posedge clk);
        #1;
        chk("out", 32'(out), 32'(exp_out_q.pop_front()));
    endtask

    task automatic chk_reset_vals();
        chk("rst_out",        32'(out),        32'd0);
        chk("rst_cfg_ready",  32'(cfg_ready),  32'd0);
        chk("rst_sweep_busy", 32'(sweep_busy), 32'd0);
        chk("rst_sweep_done", 32'(sweep_done), 32'd0);
        chk("rst_mism_cnt",   32'(mism_cnt),   32'd0);
        chk("rst_first_mism", 32'(first_mism), 32'd0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("ready_before_edge", 32'(cfg_ready), 32'd0);
        step();
        chk("ready_after_edge", 32'(cfg_ready), 32'd1);
    endtask

    task automatic load_tt(input logic [TT_W-1:0] tt, input int gap_after, input bit collide);
        for (int b = 0; b < TT_W / CFG_W; b++) begin
            chk("cfg_ready_load", 32'(cfg_ready), 32'd1);
            cfg_valid   = 1'b1;
            cfg_data    = tt[b*CFG_W +: CFG_W];
            sweep_start = collide && (b == 0);
            step();
            cfg_valid   = 1'b0;
            sweep_start = 1'b0;
            chk("busy_in_load", 32'(sweep_busy), 32'd0);
            if (b == gap_after) begin
                sweep_start = 1'b1;
                step();
                sweep_start = 1'b0;
                step();
                chk("busy_in_gap", 32'(sweep_busy), 32'd0);
            end
        end
        mdl_tt = tt;
        $display("load tt=%h gap_after=%0d collide=%0d", tt, gap_after, collide);
    endtask

    task automatic run_sweep(input logic [TT_W-1:0] gold, input bit poke, input int rst_at);
        sweep_exp_t e;
        int n;
        e = '0;
        for (int i = 0; i < TT_W; i++) begin
            if (mdl_tt[i] !== gold[i]) begin
                if (e.cnt == 0) e.first = N_IN'(i);
                e.cnt = e.cnt + 1'b1;
            end
        end
        sweep_q.push_back(e);
        golden_tt   = gold;
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        n = 1;
        chk("busy_start", 32'(sweep_busy), 32'd1);
        chk("ready_in_sweep", 32'(cfg_ready), 32'd0);
        while (!sweep_done && n < 40) begin
            if (n == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk_reset_vals();
                exp_out_q.delete();
                sweep_q.delete();
                mdl_tt = RST_TT;
                release_reset();
                $display("sweep golden=%h aborted by reset at cycle %0d", gold, n);
                return;
            end
            sweep_start = poke && (n == 3);
            step();
            sweep_start = 1'b0;
            n++;
        end
        chk("sweep_latency", 32'(n), 32'd17);
        chk("busy_at_done", 32'(sweep_busy), 32'd0);
        e = sweep_q.pop_front();
        chk("mism_cnt", 32'(mism_cnt), 32'(e.cnt));
        chk("first_mism", 32'(first_mism), 32'(e.first));
        step();
        chk("done_one_pulse", 32'(sweep_done), 32'd0);
        chk("ready_after_sweep", 32'(cfg_ready), 32'd1);
        step();
        chk("mism_cnt_hold", 32'(mism_cnt), 32'(e.cnt));
        chk("done_stays_low", 32'(sweep_done), 32'd0);
        $display("sweep golden=%h mism_cnt=%0d first_mism=%0d", gold, mism_cnt, first_mism);
    endtask

    initial begin
        rst_n       = 1'b0;
        in_vec      = '0;
        cfg_valid   = 1'b0;
        cfg_data    = '0;
        sweep_start = 1'b0;
        golden_tt   = '0;
        mdl_tt      = RST_TT;
        #12;
        chk_reset_vals();
        release_reset();

        in_vec = 4'h0;
        step();
        in_vec = 4'h2;
        step();

        run_sweep(16'hD4E4, 1'b0, 0);
        run_sweep(16'hD4E5, 1'b0, 0);
        run_sweep(16'h2B1B, 1'b1, 0);
        run_sweep(16'hD4E4 ^ 16'h0120, 1'b0, 0);
        run_sweep(16'hD4E4 ^ 16'h8000, 1'b0, 0);

        in_vec = 4'h0;
        load_tt(16'hFFFF, 1, 1'b0);
        step();
        run_sweep(16'hFFFF, 1'b0, 0);

        load_tt(16'h5A3C, -1, 1'b1);
        for (int k = 0; k < 24; k++) begin
            in_vec = N_IN'($urandom_range(0, 15));
            step();
        end
        run_sweep(16'h5A3C ^ 16'h0410, 1'b0, 0);

        load_tt(TT_W'($urandom), -1, 1'b0);
        for (int k = 0; k < 16; k++) begin
            in_vec = N_IN'(k);
            step();
        end

        load_tt(16'hFFFF, -1, 1'b0);
        run_sweep(16'hD4E4, 1'b0, 5);
        run_sweep(16'hD4E4, 1'b0, 0);
        in_vec = 4'h2;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tt_lut_eval.md
TT_LUT_EVAL -- requirements
Module: tt_lut_eval

Interface
REQ-001 Parameter N_IN, default 4, is the number of logic inputs, legal range 2..6.
REQ-002 Parameter CFG_W, default 4, is the config beat width; 2**N_IN SHALL be a multiple of CFG_W.
REQ-003 Parameter RESET_TT, default 16'hD4E4 (width 2**N_IN), is the truth table loaded at reset.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_vec  in  N_IN  logic inputs; in_vec value is the truth-table bit index.
REQ-007 out  out  1  registered function output.
REQ-008 cfg_valid  in  1  config beat offered.
REQ-009 cfg_ready  out  1  config beat accepted when cfg_valid and cfg_ready are both 1.
REQ-010 cfg_data  in  CFG_W  config beat, least significant chunk first.
REQ-011 sweep_start  in  1  one-cycle request to self-check the active table.
REQ-012 golden_tt  in  2**N_IN  expected table; held stable while sweep_busy is 1.
REQ-013 sweep_busy  out  1  sweep in progress.
REQ-014 sweep_done  out  1  one-cycle pulse at sweep end.
REQ-015 mism_cnt  out  N_IN+1  number of mismatching table entries.
REQ-016 first_mism  out  N_IN  lowest mismatching index; 0 if none.

Function
REQ-017 out SHALL equal active_tt[in_vec] sampled at the previous edge, giving 1-cycle latency in every state.
REQ-018 The FSM SHALL have states IDLE, LOAD, SWEEP and DONE.
REQ-019 IDLE SHALL hold cfg_ready at 1; an accepted beat goes to shadow chunk 0 and moves the FSM to LOAD, or commits directly when only one beat is needed.
REQ-020 LOAD SHALL hold cfg_ready at 1 and write each accepted beat to the next shadow chunk; a cfg_valid gap SHALL stall without loss.
REQ-021 On the final beat, active_tt SHALL become the shadow table at that edge, the FSM SHALL return to IDLE, and out SHALL use the new table from the next edge.
REQ-022 active_tt SHALL stay unchanged during a partial load.
REQ-023 sweep_start SHALL be honoured only in IDLE with no beat accepted that cycle; in LOAD, SWEEP or DONE it SHALL be ignored; if it coincides with an accepted beat, the beat wins and the start is dropped.
REQ-024 In SWEEP, cfg_ready SHALL be 0 and sweep_busy SHALL be 1.
REQ-025 In SWEEP, index idx SHALL step 0 to 2**N_IN-1, one per cycle, comparing active_tt[idx] with golden_tt[idx].
REQ-026 With start sampled at edge t, idx 0 SHALL be evaluated in cycle t+1 and the last index in cycle t+2**N_IN; DONE SHALL follow with sweep_done=1 and sweep_busy=0, then the FSM SHALL return to IDLE.
REQ-027 mism_cnt and first_mism SHALL clear at sweep start, update during SWEEP, and hold after DONE until the next start; mism_cnt SHALL reach 2**N_IN without overflow.
REQ-028 The idx counter SHALL not wrap; the final index SHALL end the sweep.

Reset
REQ-029 Asserting rst_n=0 SHALL immediately set FSM=IDLE, active_tt=shadow=RESET_TT, out=0, cfg_ready=0, sweep_busy=0, sweep_done=0, mism_cnt=0, first_mism=0 and idx=0.
REQ-030 cfg_ready SHALL rise on the first edge after rst_n deassertion.
REQ-031 Reset during LOAD or SWEEP SHALL abort the operation with no partial commit.

Structure
REQ-032 A shared package tt_lut_pkg SHALL hold the FSM state enum and the default-table constant.
REQ-033 The single sub-module tt_cfg_shift SHALL implement shadow chunk assembly and the commit strobe.

Verification
REQ-034 Reset with default table, in_vec=4'h0 then 4'h2 -> out=0, then out=1, each one cycle after its input.
REQ-035 Sweep with golden 16'hD4E4 -> sweep_done 17 cycles after start, mism_cnt=0, first_mism=0.
REQ-036 Sweep with golden 16'hD4E5 -> mism_cnt=1, first_mism=0; with golden 16'h2B1B -> mism_cnt=16.
REQ-037 Load 16'hFFFF in 4 beats with a 2-cycle gap after beat 2, in_vec=4'h0 -> out stays 0 through beat 3 and is 1 the cycle after beat 4.
REQ-038 sweep_start and an accepted cfg beat in the same IDLE cycle -> FSM enters LOAD and sweep_busy stays 0; sweep_start during SWEEP -> ignored, sweep_done pulses once.
REQ-039 rst_n=0 at sweep cycle 5 -> all outputs at reset values, active_tt=16'hD4E4, cfg_ready=1 one edge after release.
